// File: rtl/mem_pipe.sv
// mem_pipe: single-port word memory behind a valid/ready request channel,
// with an in-order response FIFO. Every accepted request (read or write)
// returns exactly one response. After reset the array is swept to zero
// (init_done_o rises once that completes). Addresses >= DEPTH are answered
// with rsp_err_o=1 and leave the memory untouched.
//
// Ports:
//   clk_i, rst_ni        clock (rising edge), async active-low reset
//   req_val_i/req_rdy_o  request handshake
//   req_we_i             0 = read, 1 = write
//   req_addr_i           word address
//   req_wdata_i          write data
//   req_be_i             byte enables for writes
//   rsp_val_o/rsp_rdy_i  response handshake
//   rsp_rdata_o          read data (0 for writes and errors)
//   rsp_we_o             echo of the answered request's req_we_i
//   rsp_err_o            answered request was out of range
//   init_done_o          clear sweep complete
module mem_pipe #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 128,
  parameter int unsigned RSP_DEPTH = 2,
  localparam int unsigned ADDR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned BE_W     = DATA_W / 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_val_i,
  output logic              req_rdy_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  input  logic [BE_W-1:0]   req_be_i,
  output logic              rsp_val_o,
  input  logic              rsp_rdy_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_we_o,
  output logic              rsp_err_o,
  output logic              init_done_o
);

  localparam int unsigned PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int unsigned ENT_W = DATA_W + 2;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ENT_W-1:0]  fifo_q [RSP_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              accept;
  logic              pop;
  logic              addr_ok;
  logic [DATA_W-1:0] rd_word;
  logic [ENT_W-1:0]  push_ent;
  logic [ENT_W-1:0]  head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    req_rdy_o   = 1'b0;
    init_done_o = 1'b0;
    case (state_q)
      ST_INIT: begin
        ptr_d = ptr_q + ADDR_W'(1);
        if (ptr_q == ADDR_W'(DEPTH - 1)) begin
          state_d = ST_RUN;
          ptr_d   = '0;
        end
      end
      ST_RUN: begin
        init_done_o = 1'b1;
        // Only registered occupancy feeds ready, so rsp_rdy_i never
        // reaches req_rdy_o combinationally.
        req_rdy_o   = (cnt_q < CNT_W'(RSP_DEPTH));
      end
      default: begin
        state_d = ST_INIT;
        ptr_d   = '0;
      end
    endcase
  end

  // ------------------------------------------------------------- memory
  assign accept  = req_val_i & req_rdy_o;
  assign addr_ok = (32'(req_addr_i) < DEPTH);
  assign rd_word = mem[req_addr_i];

  always_ff @(posedge clk_i) begin
    if (state_q == ST_INIT) begin
      mem[ptr_q] <= '0;
    end else if (accept && req_we_i && addr_ok) begin
      for (int unsigned i = 0; i < BE_W; i++) begin
        if (req_be_i[i]) begin
          mem[req_addr_i][8*i +: 8] <= req_wdata_i[8*i +: 8];
        end
      end
    end
  end

  // ------------------------------------------------------ response FIFO
  // Entry layout: {we, err, rdata}. Read data is captured at the accepting
  // edge, i.e. before any write that edge might perform.
  assign push_ent = {req_we_i, ~addr_ok,
                     (!req_we_i && addr_ok) ? rd_word : {DATA_W{1'b0}}};

  always_ff @(posedge clk_i) begin
    if (accept) begin
      fifo_q[wr_ptr_q] <= push_ent;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (accept) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)    rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({accept, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage is unreset; outputs are gated by occupancy so an empty FIFO
  // (including during reset) presents all-zero response fields.
  assign head        = fifo_q[rd_ptr_q];
  assign rsp_val_o   = (cnt_q != '0);
  assign pop         = rsp_val_o & rsp_rdy_i;
  assign rsp_we_o    = rsp_val_o & head[ENT_W-1];
  assign rsp_err_o   = rsp_val_o & head[ENT_W-2];
  assign rsp_rdata_o = rsp_val_o ? head[DATA_W-1:0] : '0;

endmodule
